// File: rtl/game_pkg.sv
// Shared state and winner encodings for the cat-vs-dog match controller.
package game_pkg;

  typedef enum logic [2:0] {
    START_SCREEN  = 3'b000,
    PLAYER_TURN   = 3'b001,
    OPPONENT_TURN = 3'b010,
    CHECK_WIN     = 3'b011,
    GAME_OVER     = 3'b100,
    ROUND_OVER    = 3'b101
  } state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_DOG  = 2'b01,
    WIN_CAT  = 2'b10
  } winner_t;

  // A zero timeout still needs a 1-bit counter.
  function automatic int unsigned timer_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Per-turn countdown: load to TURN_TIMEOUT, decrement while enabled and nonzero.
module turn_timer #(
  parameter int unsigned TURN_TIMEOUT = 0,
  parameter int unsigned TIMER_W      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               en,
  output logic [TIMER_W-1:0] count,
  output logic               expire
);

  localparam logic [TIMER_W-1:0] LOAD_VAL = TIMER_W'(TURN_TIMEOUT);
  localparam logic [TIMER_W-1:0] ONE      = TIMER_W'(1);

  logic [TIMER_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst)
      count_q <= '0;
    else if (load)
      count_q <= LOAD_VAL;
    else if (en && count_q != '0)
      count_q <= count_q - ONE;
  end

  assign count  = count_q;
  // With TURN_TIMEOUT=0 the count never reaches 1, so expiry is impossible.
  assign expire = en && (count_q == ONE);

endmodule

// File: rtl/match_fsm.sv
// Best-of-N match controller: start screen, alternating turns with timeout,
// round scoring and game over. All outputs come straight from registers.
module match_fsm
  import game_pkg::*;
#(
  parameter int unsigned HP_W          = 10,
  parameter int unsigned TURN_TIMEOUT  = 0,
  parameter int unsigned ROUNDS_TO_WIN = 2,
  parameter int unsigned TIMER_W       = timer_width(TURN_TIMEOUT),
  parameter int unsigned ROUND_W       = $clog2(ROUNDS_TO_WIN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enter_pressed_local,
  input  logic               enter_pressed_remote,
  input  logic               turn_done_dog,
  input  logic               turn_done_cat,
  input  logic [HP_W-1:0]    hp_local,
  input  logic [HP_W-1:0]    hp_remote,
  output logic               dog_turn,
  output logic               cat_turn,
  output logic [2:0]         state_game_fsm,
  output logic               next_turn,
  output logic               enter_start_remote,
  output logic               reset_hp,
  output logic               turn_timeout,
  output logic [TIMER_W-1:0] turn_time_left,
  output logic [ROUND_W-1:0] score_dog,
  output logic [ROUND_W-1:0] score_cat,
  output logic [1:0]         winner
);

  localparam logic [ROUND_W-1:0] ROUND_MAX = ROUND_W'(ROUNDS_TO_WIN);
  localparam logic [ROUND_W-1:0] ROUND_ONE = ROUND_W'(1);

  state_t             state_q;
  winner_t            winner_q, round_res_q;
  logic               dog_turn_q, cat_turn_q, next_turn_q;
  logic               enter_start_remote_q, reset_hp_q, turn_timeout_q;
  logic [ROUND_W-1:0] score_dog_q, score_cat_q;

  logic tmr_load, tmr_en, tmr_expire;
  logic any_enter, dog_dead, cat_dead, dog_full, cat_full, turn_done;

  assign any_enter = enter_pressed_local || enter_pressed_remote;
  assign dog_dead  = (hp_local == '0);
  assign cat_dead  = (hp_remote == '0);
  assign dog_full  = (score_dog_q == ROUND_MAX);
  assign cat_full  = (score_cat_q == ROUND_MAX);
  assign turn_done = (state_q == PLAYER_TURN   && turn_done_dog) ||
                     (state_q == OPPONENT_TURN && turn_done_cat);
  assign tmr_en    = (state_q == PLAYER_TURN) || (state_q == OPPONENT_TURN);

  // Load on exactly the transitions that enter a turn state.
  always_comb begin
    tmr_load = 1'b0;
    case (state_q)
      START_SCREEN: tmr_load = any_enter;
      CHECK_WIN:    tmr_load = !(dog_dead || cat_dead);
      ROUND_OVER:   tmr_load = !(dog_full || cat_full);
      default:      tmr_load = 1'b0;
    endcase
  end

  turn_timer #(
    .TURN_TIMEOUT (TURN_TIMEOUT),
    .TIMER_W      (TIMER_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .en     (tmr_en),
    .count  (turn_time_left),
    .expire (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= START_SCREEN;
      winner_q             <= WIN_NONE;
      round_res_q          <= WIN_NONE;
      dog_turn_q           <= 1'b0;
      cat_turn_q           <= 1'b0;
      next_turn_q          <= 1'b0;
      enter_start_remote_q <= 1'b0;
      reset_hp_q           <= 1'b0;
      turn_timeout_q       <= 1'b0;
      score_dog_q          <= '0;
      score_cat_q          <= '0;
    end else begin
      enter_start_remote_q <= 1'b0;
      turn_timeout_q       <= 1'b0;
      case (state_q)
        START_SCREEN: begin
          reset_hp_q  <= 1'b1;
          next_turn_q <= 1'b0;
          dog_turn_q  <= 1'b0;
          cat_turn_q  <= 1'b0;
          score_dog_q <= '0;
          score_cat_q <= '0;
          winner_q    <= WIN_NONE;
          if (enter_pressed_local) begin
            state_q     <= PLAYER_TURN;
            dog_turn_q  <= 1'b1;
            next_turn_q <= 1'b1;
            reset_hp_q  <= 1'b0;
          end else if (enter_pressed_remote) begin
            state_q              <= OPPONENT_TURN;
            cat_turn_q           <= 1'b1;
            next_turn_q          <= 1'b1;
            reset_hp_q           <= 1'b0;
            enter_start_remote_q <= 1'b1;
          end
        end
        PLAYER_TURN, OPPONENT_TURN: begin
          if (turn_done) begin
            state_q     <= CHECK_WIN;
            next_turn_q <= 1'b0;
          end else if (tmr_expire) begin
            state_q        <= CHECK_WIN;
            next_turn_q    <= 1'b0;
            turn_timeout_q <= 1'b1;
          end
        end
        CHECK_WIN: begin
          if (dog_dead || cat_dead) begin
            state_q    <= ROUND_OVER;
            dog_turn_q <= 1'b0;
            cat_turn_q <= 1'b0;
            reset_hp_q <= 1'b1;
            if (dog_dead && cat_dead) begin
              round_res_q <= WIN_NONE;
            end else if (dog_dead) begin
              round_res_q <= WIN_CAT;
              if (!cat_full) score_cat_q <= score_cat_q + ROUND_ONE;
            end else begin
              round_res_q <= WIN_DOG;
              if (!dog_full) score_dog_q <= score_dog_q + ROUND_ONE;
            end
          end else begin
            state_q     <= dog_turn_q ? OPPONENT_TURN : PLAYER_TURN;
            dog_turn_q  <= cat_turn_q;
            cat_turn_q  <= dog_turn_q;
            next_turn_q <= 1'b1;
          end
        end
        ROUND_OVER: begin
          reset_hp_q <= 1'b0;
          if (dog_full) begin
            state_q  <= GAME_OVER;
            winner_q <= WIN_DOG;
          end else if (cat_full) begin
            state_q  <= GAME_OVER;
            winner_q <= WIN_CAT;
          end else if (round_res_q == WIN_DOG) begin
            // The round loser opens the next round; dog opens after a draw.
            state_q     <= OPPONENT_TURN;
            cat_turn_q  <= 1'b1;
            next_turn_q <= 1'b1;
          end else begin
            state_q     <= PLAYER_TURN;
            dog_turn_q  <= 1'b1;
            next_turn_q <= 1'b1;
          end
        end
        GAME_OVER: begin
          dog_turn_q  <= 1'b0;
          cat_turn_q  <= 1'b0;
          next_turn_q <= 1'b0;
          if (any_enter) begin
            state_q     <= START_SCREEN;
            reset_hp_q  <= 1'b1;
            score_dog_q <= '0;
            score_cat_q <= '0;
            winner_q    <= WIN_NONE;
          end
        end
        default: begin
          state_q     <= START_SCREEN;
          dog_turn_q  <= 1'b0;
          cat_turn_q  <= 1'b0;
          next_turn_q <= 1'b0;
        end
      endcase
    end
  end

  assign state_game_fsm     = state_q;
  assign dog_turn           = dog_turn_q;
  assign cat_turn           = cat_turn_q;
  assign next_turn          = next_turn_q;
  assign enter_start_remote = enter_start_remote_q;
  assign reset_hp           = reset_hp_q;
  assign turn_timeout       = turn_timeout_q;
  assign score_dog          = score_dog_q;
  assign score_cat          = score_cat_q;
  assign winner             = winner_q;

endmodule
